// File: rtl/gain_cfg_sequencer.sv
// ============================================================================
// gain_cfg_sequencer : initializes reg_map, then serializes queued config/gain
//                      commands into one-byte-per-cycle register writes.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gain_cfg_sequencer #(
   parameter int         GAIN_WIDTH  = 24,
   parameter int         ADDR_WIDTH  = 5,
   parameter int         FIFO_DEPTH  = 4,
   parameter logic [7:0] CFG_DEFAULT = 8'h00,
   parameter int         GAIN_MIN    = -24,
   parameter int         GAIN_MAX    = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [3:0]            cmd_band,
   input  logic [GAIN_WIDTH-1:0] cmd_data,
   output logic                  reg_we,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic [7:0]            reg_wdata,
   output logic                  busy,
   output logic                  init_done,
   output logic                  done,
   output logic                  cmd_err
);

   localparam int                    c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int                    c_CNT_W    = ADDR_WIDTH + 1;
   localparam logic [c_CNT_W-1:0]    c_INIT_END = c_CNT_W'(31);
   localparam logic [c_PTR_W:0]      c_FULL     = (c_PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [GAIN_WIDTH-1:0] c_GMIN     = GAIN_WIDTH'(GAIN_MIN);
   localparam logic [GAIN_WIDTH-1:0] c_GMAX     = GAIN_WIDTH'(GAIN_MAX);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_IDLE   = 3'd1,
      S_WR_CFG = 3'd2,
      S_WR_LSB = 3'd3,
      S_WR_MID = 3'd4,
      S_WR_MSB = 3'd5
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [c_CNT_W-1:0]    r_init_cnt, w_cnt_nxt;
   logic [GAIN_WIDTH-1:0] r_gain, w_sat;
   logic [ADDR_WIDTH-1:0] r_base, w_base;
   logic                  r_fin, w_fin;
   logic                  w_we, w_pop, w_err, w_init_set;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [7:0]            w_wdata;

   logic [3:0]            r_fifo_band [FIFO_DEPTH];
   logic [GAIN_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
   logic [c_PTR_W-1:0]    r_wptr, r_rptr;
   logic [c_PTR_W:0]      r_count;
   logic                  w_push, w_empty, w_full;
   logic [3:0]            w_head_band;
   logic [GAIN_WIDTH-1:0] w_head_data;

   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == c_FULL);
   assign w_push      = cmd_valid & ~w_full;
   assign w_head_band = r_fifo_band[r_rptr];
   assign w_head_data = r_fifo_data[r_rptr];
   assign cmd_ready   = ~w_full;
   assign busy        = (r_state != S_IDLE) || !w_empty;

   // Storage needs no reset: flushing is done by clearing the pointers.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_band[r_wptr] <= cmd_band;
         r_fifo_data[r_wptr] <= cmd_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      w_sat = w_head_data;
      if ($signed(w_head_data) > $signed(c_GMAX))
         w_sat = c_GMAX;
      else if ($signed(w_head_data) < $signed(c_GMIN))
         w_sat = c_GMIN;
   end

   assign w_base = ADDR_WIDTH'(3 * int'(w_head_band) - 2);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_init_cnt;
      w_we        = 1'b0;
      w_addr      = reg_addr;
      w_wdata     = reg_wdata;
      w_pop       = 1'b0;
      w_err       = 1'b0;
      w_fin       = 1'b0;
      w_init_set  = 1'b0;
      case (r_state)
         S_INIT: begin
            if (r_init_cnt == c_INIT_END) begin
               w_state_nxt = S_IDLE;
               w_init_set  = 1'b1;
            end else begin
               w_we      = 1'b1;
               w_addr    = r_init_cnt[ADDR_WIDTH-1:0];
               w_wdata   = (r_init_cnt == '0) ? CFG_DEFAULT : 8'h00;
               w_cnt_nxt = r_init_cnt + 1'b1;
            end
         end
         S_IDLE: begin
            if (!w_empty) begin
               w_pop = 1'b1;
               if (w_head_band == 4'd0)
                  w_state_nxt = S_WR_CFG;
               else if (w_head_band <= 4'd10)
                  w_state_nxt = S_WR_LSB;
               else
                  w_err = 1'b1;
            end
         end
         S_WR_CFG: begin
            w_we        = 1'b1;
            w_addr      = '0;
            w_wdata     = r_gain[7:0];
            w_fin       = 1'b1;
            w_state_nxt = S_IDLE;
         end
         S_WR_LSB: begin
            w_we        = 1'b1;
            w_addr      = r_base;
            w_wdata     = r_gain[7:0];
            w_state_nxt = S_WR_MID;
         end
         S_WR_MID: begin
            w_we        = 1'b1;
            w_addr      = r_base + ADDR_WIDTH'(1);
            w_wdata     = r_gain[15:8];
            w_state_nxt = S_WR_MSB;
         end
         S_WR_MSB: begin
            w_we        = 1'b1;
            w_addr      = r_base + ADDR_WIDTH'(2);
            w_wdata     = r_gain[23:16];
            w_fin       = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_INIT;
      endcase
   end

   // done trails the final write by one cycle, so it is staged through r_fin.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_INIT;
         r_init_cnt <= '0;
         r_gain     <= '0;
         r_base     <= '0;
         r_fin      <= 1'b0;
         reg_we     <= 1'b0;
         reg_addr   <= '0;
         reg_wdata  <= '0;
         done       <= 1'b0;
         cmd_err    <= 1'b0;
         init_done  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_init_cnt <= w_cnt_nxt;
         r_fin      <= w_fin;
         reg_we     <= w_we;
         reg_addr   <= w_addr;
         reg_wdata  <= w_wdata;
         done       <= r_fin;
         cmd_err    <= w_err;
         if (w_init_set) init_done <= 1'b1;
         if (w_pop) begin
            r_gain <= (w_head_band == 4'd0) ? w_head_data : w_sat;
            r_base <= w_base;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_gain_cfg_sequencer.sv
// ============================================================================
// tb_gain_cfg_sequencer : scoreboard bench with a behavioural register model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gain_cfg_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [3:0]  cmd_band;
   logic [23:0] cmd_data;
   logic        reg_we;
   logic [4:0]  reg_addr;
   logic [7:0]  reg_wdata;
   logic        busy, init_done, done, cmd_err;

   gain_cfg_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_band  (cmd_band),
      .cmd_data  (cmd_data),
      .reg_we    (reg_we),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .busy      (busy),
      .init_done (init_done),
      .done      (done),
      .cmd_err   (cmd_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         kind;   // 0 write, 1 done, 2 cmd_err
      logic [4:0] addr;
      logic [7:0] data;
   } ev_t;

   ev_t         exp_q[$];
   int          wr_cyc_q[$];
   int          done_cyc_q[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  model_mem [32];
   logic [7:0]  obs_mem   [32];
   logic [23:0] model_gain [11];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] clamp(input logic [23:0] d);
      int v;
      v = $signed(d);
      if (v > 24)  v = 24;
      if (v < -24) v = -24;
      return v[23:0];
   endfunction

   function automatic void push_ev(input int k, input logic [4:0] a, input logic [7:0] d);
      ev_t e;
      e.kind = k; e.addr = a; e.data = d;
      exp_q.push_back(e);
      if (k == 0) model_mem[a] = d;
   endfunction

   // Model of the register bank after a fresh initialization sweep.
   function automatic void push_init();
      for (int a = 0; a < 31; a++) push_ev(0, 5'(a), (a == 0) ? 8'h00 : 8'h00);
      for (int b = 0; b < 11; b++) model_gain[b] = '0;
   endfunction

   function automatic void push_cmd(input logic [3:0] b, input logic [23:0] d);
      logic [23:0] g;
      int          base;
      if (b == 0) begin
         push_ev(0, 5'd0, d[7:0]);
         push_ev(1, 5'd0, 8'd0);
      end else if (b <= 10) begin
         g    = clamp(d);
         base = 3 * int'(b) - 2;
         push_ev(0, 5'(base),     g[7:0]);
         push_ev(0, 5'(base + 1), g[15:8]);
         push_ev(0, 5'(base + 2), g[23:16]);
         push_ev(1, 5'd0, 8'd0);
         model_gain[b] = g;
      end else begin
         push_ev(2, 5'd0, 8'd0);
      end
   endfunction

   task automatic expect_ev(input int k, input logic [4:0] a, input logic [7:0] d);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind %0d addr %0d data %0h expected none", k, a, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || (k == 0 && (e.addr !== a || e.data !== d))) begin
            errors++;
            $display("FAIL event: got kind %0d addr %0d data %0h expected kind %0d addr %0d data %0h",
                     k, a, d, e.kind, e.addr, e.data);
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            if (reg_we) begin
               obs_mem[reg_addr] = reg_wdata;
               wr_cyc_q.push_back(cyc);
               expect_ev(0, reg_addr, reg_wdata);
            end
            if (done) begin
               done_cyc_q.push_back(cyc);
               expect_ev(1, 5'd0, 8'd0);
            end
            if (cmd_err) expect_ev(2, 5'd0, 8'd0);
         end
      end
   end

   // Called at a negedge; returns at the negedge after the transfer edge.
   task automatic send(input logic [3:0] b, input int d, output int acc);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_band  = b;
      cmd_data  = d[23:0];
      while (!cmd_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) begin
         $display("FAIL send_timeout: got cmd_ready 0 expected 1");
         errors++;
         checks++;
         acc = -1;
      end else begin
         acc = cyc + 1;
         push_cmd(b, d[23:0]);
         @(negedge clk);
      end
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || busy || done || cmd_err) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk(name, (n < 2000) ? 1 : 0, 1);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_reg_we"},    32'(reg_we),    0);
      chk({tag, "_reg_addr"},  32'(reg_addr),  0);
      chk({tag, "_reg_wdata"}, 32'(reg_wdata), 0);
      chk({tag, "_done"},      32'(done),      0);
      chk({tag, "_cmd_err"},   32'(cmd_err),   0);
      chk({tag, "_init_done"}, 32'(init_done), 0);
      chk({tag, "_busy"},      32'(busy),      1);
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
   endtask

   initial begin
      int acc0, acc1, dummy, k, n, d, b;
      rst = 1'b1; cmd_valid = 1'b0; cmd_band = '0; cmd_data = '0;
      for (int i = 0; i < 32; i++) begin model_mem[i] = 8'hxx; obs_mem[i] = 8'hxx; end
      repeat (3) @(negedge clk);
      check_reset_vals("rst");

      // Initialization sweep timing
      push_init();
      wr_cyc_q.delete();
      k = cyc;
      rst = 1'b0;
      n = 0;
      while (!init_done && n < 100) begin @(negedge clk); n++; end
      chk("init_done_cycle", cyc, k + 32);
      wait_idle("init_drain");
      chk("init_first_we_cycle", (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : -1, k + 1);
      chk("init_last_we_cycle", (wr_cyc_q.size() == 31) ? wr_cyc_q[30] : -1, k + 31);

      // Config then gain, latency and back-to-back spacing
      wr_cyc_q.delete(); done_cyc_q.delete();
      send(4'd0, 32'h0000AA, acc0);
      send(4'd1, -19, acc1);
      cmd_valid = 1'b0;
      wait_idle("cfg_gain_drain");
      chk("cfg_we_cycle", (wr_cyc_q.size() == 4) ? wr_cyc_q[0] : -1, acc0 + 2);
      chk("gain_lsb_cycle", (wr_cyc_q.size() == 4) ? wr_cyc_q[1] : -1, acc0 + 4);
      chk("gain_msb_cycle", (wr_cyc_q.size() == 4) ? wr_cyc_q[3] : -1, acc0 + 6);
      chk("cfg_done_cycle", (done_cyc_q.size() == 2) ? done_cyc_q[0] : -1, acc0 + 3);
      chk("gain_done_cycle", (done_cyc_q.size() == 2) ? done_cyc_q[1] : -1, acc0 + 7);
      chk("gain1_bytes", {8'h0, obs_mem[3], obs_mem[2], obs_mem[1]}, 32'h00FFFFED);

      // Saturation at both bounds
      send(4'd10, 100, dummy);
      send(4'd5, -1000, dummy);
      cmd_valid = 1'b0;
      wait_idle("sat_drain");
      chk("gain10_sat", {8'h0, obs_mem[30], obs_mem[29], obs_mem[28]}, 32'h00000018);
      chk("gain5_sat", {8'h0, obs_mem[15], obs_mem[14], obs_mem[13]}, 32'h00FFFFE8);

      // Illegal band between two legal gains
      send(4'd2, 5, dummy);
      send(4'd12, 7, dummy);
      send(4'd4, -3, dummy);
      cmd_valid = 1'b0;
      wait_idle("illegal_drain");

      // FIFO full while the initialization sweep is running
      rst = 1'b1;
      @(negedge clk);
      exp_q.delete();
      push_init();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         send(4'(i + 1), (i * 7) - 20, dummy);
         if (i == 3) chk("fifo_full_ready", 32'(cmd_ready), 0);
      end
      cmd_valid = 1'b0;
      wait_idle("fifo_full_drain");

      // Randomized commands with random gaps
      for (int i = 0; i < 40; i++) begin
         b = $urandom_range(0, 19);
         if (b > 15) b = $urandom_range(0, 10);
         case ($urandom_range(0, 3))
            0:       d = int'($urandom_range(0, 60)) - 30;
            1:       d = int'($urandom);
            2:       d = int'($urandom_range(25, 8388607));
            default: d = -int'($urandom_range(25, 8388608));
         endcase
         send(4'(b), d, dummy);
         if ($urandom_range(0, 2) == 0) begin
            cmd_valid = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge clk);
         end
      end
      cmd_valid = 1'b0;
      wait_idle("random_drain");

      // Reset during the middle byte of a band-3 write, with commands queued
      send(4'd3, 24'h012345 & 32'h00000010, dummy);
      send(4'd7, 9, dummy);
      send(4'd0, 32'h55, dummy);
      cmd_valid = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!(reg_we && reg_addr == 5'd8) && n < 50);
      chk("mid_write_seen", (n < 50) ? 1 : 0, 1);
      #2;
      rst = 1'b1;
      #1;
      check_reset_vals("async_rst");
      exp_q.delete();
      push_init();
      @(negedge clk);
      @(negedge clk);
      chk("flushed_ready", 32'(cmd_ready), 1);
      wr_cyc_q.delete();
      k = cyc;
      rst = 1'b0;
      wait_idle("reinit_drain");
      chk("reinit_first_cycle", (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : -1, k + 1);
      chk("reinit_count", wr_cyc_q.size(), 31);

      // Final register contents against the model
      for (int a = 0; a < 31; a++) chk($sformatf("mem_%0d", a), 32'(obs_mem[a]), 32'(model_mem[a]));
      for (int g = 1; g <= 10; g++)
         chk($sformatf("gain_%0d", g), {8'h0, obs_mem[3*g], obs_mem[3*g-1], obs_mem[3*g-2]},
             {8'h0, model_gain[g]});
      chk("final_init_done", 32'(init_done), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/gain_cfg_sequencer.md
# gain_cfg_sequencer

Write sequencer for the equalizer register bank (`reg_map`). After reset it initializes all 31 byte registers: configuration to a default and every band gain to 0. It then accepts configuration and per-band gain commands from the host through a 4-entry command FIFO. Each command is saturated and serialized into the one-byte-per-cycle write protocol of `reg_map`: `we`/`addr`/`data_in`, with gains written LSB, MID, MSB.

## Interface
- GAIN_WIDTH, 24, signed gain width in dB steps; must match `reg_map`.
- ADDR_WIDTH, 5, width of `reg_addr`; must hold addresses 0..30.
- FIFO_DEPTH, 4, command FIFO entries; power of two.
- CFG_DEFAULT, 8'h00, configuration byte written during initialization.
- GAIN_MIN, -24, lower saturation bound (signed).
- GAIN_MAX, 24, upper saturation bound (signed).

Ports (clock and reset first):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  FIFO not full; a command transfers when `cmd_valid & cmd_ready` at a rising edge.
- cmd_band  in  4  0 = configuration, 1..10 = band index, 11..15 = illegal.
- cmd_data  in  GAIN_WIDTH  signed gain; for band 0 only [7:0] is used.
- reg_we  out  1  to `reg_map` `we`.
- reg_addr  out  ADDR_WIDTH  to `reg_map` `addr`.
- reg_wdata  out  8  to `reg_map` `data_in`.
- busy  out  1  high when state ≠ IDLE or the FIFO is non-empty.
- init_done  out  1  goes high after the initialization sweep; stays high until reset.
- done  out  1  one-cycle pulse after the last byte of a legal command.
- cmd_err  out  1  one-cycle pulse when an illegal-band command is popped.

## Operation
- Address map:
  - Configuration is written at address 0.
  - Band b (1..10) is written at addresses 3b-2 (bits [7:0]), 3b-1 ([15:8]) and 3b ([23:16]).
- States: INIT, IDLE, WR_CFG, WR_LSB, WR_MID, WR_MSB.
- INIT:
  - Entered on reset.
  - Issues 31 consecutive writes, addresses 0..30, one per cycle.
  - Data is CFG_DEFAULT at address 0 and 8'h00 elsewhere.
  - After the address-30 write: set `init_done`, go to IDLE. No `done` pulse.
- IDLE: when the FIFO is non-empty, pop the head entry and decode it.
  - band 0 → WR_CFG.
  - band 1..10 → WR_LSB.
  - band > 10 → pulse `cmd_err`, no write, stay IDLE.
- WR_CFG: one write of `cmd_data[7:0]` to address 0; then pulse `done`, return to IDLE.
- WR_LSB → WR_MID → WR_MSB: three consecutive write cycles of the saturated gain.
  - After WR_MSB: pulse `done`, return to IDLE.
- Saturation is a signed compare on the full GAIN_WIDTH value: `g = max(GAIN_MIN, min(GAIN_MAX, cmd_data))`.
  - The result is held in a register for the whole 3-byte sequence.
- FIFO:
  - Accepts commands in every state, including INIT.
  - Commands are drained strictly in order.
  - A push and a pop in the same cycle are both honoured; the count is unchanged.
  - `cmd_ready` = !full, so no push is possible while full.
- While `reg_we` = 0, `reg_addr` and `reg_wdata` hold their last values.
- Reset asserted mid-sequence:
  - Immediately clears every output and flushes the FIFO.
  - A partially written gain is left in `reg_map` as is.
  - INIT restarts after reset deasserts.

## Timing
- Reset values: `reg_we` 0, `reg_addr` 0, `reg_wdata` 0, `done` 0, `cmd_err` 0, `init_done` 0, `busy` 1 (state INIT), `cmd_ready` 1 (FIFO empty).
- `reg_we`, `reg_addr`, `reg_wdata`, `done`, `cmd_err` and `init_done` are registered.
- INIT sweep:
  - First `reg_we` cycle is the first clock after reset deassertion.
  - 31 back-to-back `reg_we` cycles.
  - `init_done` rises on the edge that ends the address-30 write cycle.
- Command latency, with the sequencer in IDLE and the FIFO empty:
  - Command accepted at edge N → popped at edge N+1 → `reg_we` high for cycles N+2..N+4 (gain) or N+2 only (config).
  - `done` is high the cycle after the last write.
- Consecutive queued commands:
  - The next pop occurs in the `done` cycle.
  - So there is exactly one idle cycle (`reg_we` = 0) between commands.
- An illegal command costs one cycle (the `cmd_err` cycle); the next pop follows on the next edge.
- Throughput: one gain per 4 cycles, one configuration byte per 2 cycles.

## Test plan
- Reset release, no commands:
  - 31 writes at addresses 0..30 in 31 consecutive cycles, with data CFG_DEFAULT then 0s.
  - `init_done`=1 afterwards; `reg_map` reads configuration 8'h00 and all gains 0.
- After init, send band 0 = 8'hAA, then band 1 = -19 (24'hFFFFED):
  - Writes (0,AA), then (1,ED), (2,FF), (3,FF); `gain_1` reads -19; two `done` pulses.
- Saturation:
  - band 10 = +100 → addresses 28..30 get 18,00,00 (`gain_10` = +24).
  - band 5 = -1000 → addresses 13..15 get E8,FF,FF (`gain_5` = -24).
- FIFO full:
  - Push 6 commands back-to-back with `cmd_valid` held high during INIT.
  - `cmd_ready` drops after the 4th; all 6 are eventually written in order.
  - No command is lost or duplicated.
- Illegal band 12 queued between two legal gains:
  - One `cmd_err` pulse, no `reg_we` for it.
  - Neighbouring commands are written correctly.
- Assert `rst` during WR_MID of a band-3 write:
  - All outputs go to reset values asynchronously, the FIFO is emptied, and INIT reruns from address 0.
